// File: rtl/uart_axi_master.sv
// uart_axi_master
//   Host-debug bridge: parses command frames arriving from a UART receiver
//   and issues single 32-bit AXI4-Lite write or read transactions. A status
//   byte is returned through a UART transmitter interface. For reads, the
//   status byte is followed by the read data.
//
//   Frames (multi-byte fields MSB first):
//     write : 'W' (0x57), addr[31:0], data[31:0]
//     read  : 'R' (0x52), addr[31:0]
//   Reply: 'K' (0x4B) for an OKAY response, 'E' (0x45) otherwise.
//          Reads append 4 data bytes, which are sent even on error.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   rx_dv, rx_byte        received byte strobe and value
//   tx_dv, tx_byte        transmit request pulse; byte held until tx_done
//   tx_done               transmitter finished the current byte
//   m_axi_*               AXI4-Lite master port (single outstanding beat)
//   busy                  high whenever the FSM is not in IDLE
module uart_axi_master #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy
);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ST_OK     = 8'h4B;
    localparam logic [7:0] ST_ERR    = 8'h45;
    localparam int          TW           = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND, WAIT_TX
    } state_t;

    state_t         state_reg;
    logic           is_read_reg;
    logic [1:0]     byte_cnt_reg;
    logic [TW-1:0]  timeout_cnt_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    data_reg;      // write data, later reused as the read-data reply shifter
    logic [2:0]     remain_reg;    // reply bytes still to send after the current one

    assign m_axi_awaddr = addr_reg;
    assign m_axi_araddr = addr_reg;
    assign m_axi_wdata  = data_reg;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign busy         = (state_reg != IDLE);

    // tx_dv is registered, so it is raised on the edge that enters SEND.
    // The single SEND cycle is therefore the tx_dv pulse cycle, and a
    // tx_done coinciding with it is never looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            is_read_reg     <= 1'b0;
            byte_cnt_reg    <= 2'd0;
            timeout_cnt_reg <= '0;
            addr_reg        <= 32'd0;
            data_reg        <= 32'd0;
            remain_reg      <= 3'd0;
            tx_dv           <= 1'b0;
            tx_byte         <= 8'd0;
            m_axi_awvalid   <= 1'b0;
            m_axi_wvalid    <= 1'b0;
            m_axi_bready    <= 1'b0;
            m_axi_arvalid   <= 1'b0;
            m_axi_rready    <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_dv && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
                        is_read_reg     <= (rx_byte == CMD_READ);
                        byte_cnt_reg    <= 2'd0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (rx_dv) begin
                        addr_reg        <= {addr_reg[23:0], rx_byte};
                        byte_cnt_reg    <= byte_cnt_reg + 2'd1;  // wraps to 0 for GET_DATA
                        timeout_cnt_reg <= '0;
                        if (byte_cnt_reg == 2'd3) begin
                            if (is_read_reg) begin
                                m_axi_arvalid <= 1'b1;
                                state_reg     <= RD_REQ;
                            end else begin
                                state_reg     <= GET_DATA;
                            end
                        end
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                GET_DATA: begin
                    if (rx_dv) begin
                        data_reg        <= {data_reg[23:0], rx_byte};
                        byte_cnt_reg    <= byte_cnt_reg + 2'd1;
                        timeout_cnt_reg <= '0;
                        if (byte_cnt_reg == 2'd3) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state_reg     <= WR_REQ;
                        end
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                WR_REQ: begin
                    // A channel counts as finished once its valid has dropped
                    // or it is handshaking now; this covers both orders and
                    // the same-cycle case with one test.
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state_reg    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        tx_byte      <= (m_axi_bresp == 2'b00) ? ST_OK : ST_ERR;
                        tx_dv        <= 1'b1;
                        remain_reg   <= 3'd0;
                        state_reg    <= SEND;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state_reg     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        data_reg     <= m_axi_rdata;
                        tx_byte      <= (m_axi_rresp == 2'b00) ? ST_OK : ST_ERR;
                        tx_dv        <= 1'b1;
                        remain_reg   <= 3'd4;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    state_reg <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (remain_reg != 3'd0) begin
                            tx_byte    <= data_reg[31:24];
                            data_reg   <= {data_reg[23:0], 8'h00};
                            remain_reg <= remain_reg - 3'd1;
                            tx_dv      <= 1'b1;
                            state_reg  <= SEND;
                        end else begin
                            state_reg  <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
